ps2_key_decoder: RTL and testbench

- Parametrised successor to the in-game keyboard decoder. Converts the PS2 controller byte stream into per-key held levels and one-cycle press/release/auto-repeat pulses.
- Handles E0-extended and F0-break prefixes, and suppresses keyboard typematic re-makes.
- Sits between PS2_Controller and the game FSMs, replacing the hard-coded arrow/select decode.
- Runs in the CLOCK_50 domain; consumers in other clock domains resynchronise its outputs.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_key_decoder_if.sv | 24 ++
 rtl/ps2_repeat_timer.sv | 49 ++++
 rtl/ps2_key_decoder.sv | 145 ++++++++++++++
 tb/tb_ps2_key_decoder.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key decoder: prefix bytes,
// default game key map and the prefix-state encoding.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    localparam logic [7:0] CODE_UP    = 8'h75;
    localparam logic [7:0] CODE_DOWN  = 8'h72;
    localparam logic [7:0] CODE_LEFT  = 8'h6B;
    localparam logic [7:0] CODE_RIGHT = 8'h74;
    localparam logic [7:0] CODE_SPACE = 8'h29;

    // Channel 0 sits in the least significant byte.
    localparam logic [39:0] DEFAULT_KEY_CODES =
        {CODE_SPACE, CODE_RIGHT, CODE_LEFT, CODE_DOWN, CODE_UP};
    localparam logic [4:0]  DEFAULT_KEY_EXT = 5'b01111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } ps2_state_e;

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Byte-stream input and decoded key outputs of ps2_key_decoder.
// master = PS2 controller / consumer side, slave = the decoder.
interface ps2_key_decoder_if #(
    parameter int NUM_KEYS = 5
);
    logic [7:0]          received_data;
    logic                received_data_en;
    logic [NUM_KEYS-1:0] key_held;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_repeat;
    logic                any_held;
    logic [8:0]          last_code;

    modport master (
        output received_data, received_data_en,
        input  key_held, key_press, key_release, key_repeat, any_held, last_code
    );

    modport slave (
        input  received_data, received_data_en,
        output key_held, key_press, key_release, key_repeat, any_held, last_code
    );
endinterface

// File: rtl/ps2_repeat_timer.sv
// Shared auto-repeat down-counter: DELAY cycles to the first fire, then
// every PERIOD cycles until stopped. Load has priority over stop.
module ps2_repeat_timer #(
    parameter int DELAY  = 25_000_000,
    parameter int PERIOD = 5_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    input  logic stop,
    output logic fire
);

    localparam int MAX_CNT = (DELAY > PERIOD) ? DELAY : PERIOD;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;

    assign fire = run_q && (cnt_q == CNT_W'(1));

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (load) begin
            run_d = 1'b1;
            cnt_d = CNT_W'(DELAY);
        end else if (stop) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else if (run_q) begin
            // Reload at 1 so the counter never reaches 0 while running.
            cnt_d = fire ? CNT_W'(PERIOD) : cnt_q - CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Decodes the PS/2 byte stream (E0/F0 prefixes) into per-key held levels
// and registered press/release/auto-repeat pulses.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int                    NUM_KEYS      = 5,
    parameter logic [NUM_KEYS*8-1:0] KEY_CODES     = DEFAULT_KEY_CODES,
    parameter logic [NUM_KEYS-1:0]   KEY_EXT       = DEFAULT_KEY_EXT,
    parameter bit                    REPEAT_EN     = 1'b1,
    parameter int                    REPEAT_DELAY  = 25_000_000,
    parameter int                    REPEAT_PERIOD = 5_000_000
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    ps2_key_decoder_if.slave    bus
);

    localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    ps2_state_e          state_q, state_d;
    logic                is_make, is_break, ext;
    logic [7:0]          code;
    logic [NUM_KEYS-1:0] match;
    logic [NUM_KEYS-1:0] held_q, held_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;
    logic [8:0]          last_code_q, last_code_d;

    assign code = bus.received_data;

    always_comb begin
        state_d  = state_q;
        is_make  = 1'b0;
        is_break = 1'b0;
        ext      = 1'b0;
        if (bus.received_data_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (code == PS2_EXT)        state_d = ST_EXT;
                    else if (code == PS2_BRK)   state_d = ST_BRK;
                    else if (code != PS2_PAUSE) is_make = 1'b1;
                end
                ST_EXT: begin
                    if (code == PS2_BRK)        state_d = ST_EXT_BRK;
                    else if (code != PS2_EXT) begin
                        is_make = 1'b1;
                        ext     = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    state_d  = ST_IDLE;
                    is_break = (code != PS2_EXT) && (code != PS2_BRK);
                end
                ST_EXT_BRK: begin
                    state_d  = ST_IDLE;
                    ext      = 1'b1;
                    is_break = (code != PS2_EXT) && (code != PS2_BRK);
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            match[i] = (code == KEY_CODES[8*i +: 8]) && (ext == KEY_EXT[i]);
        end
    end

    // Typematic re-makes of a held key and breaks of idle keys fall out as no-ops.
    always_comb begin
        press_d     = is_make  ? (match & ~held_q) : '0;
        release_d   = is_break ? (match &  held_q) : '0;
        held_d      = (held_q | press_d) & ~release_d;
        last_code_d = (is_make || is_break) ? {ext, code} : last_code_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            held_q      <= '0;
            press_q     <= '0;
            release_q   <= '0;
            last_code_q <= '0;
        end else begin
            state_q     <= state_d;
            held_q      <= held_d;
            press_q     <= press_d;
            release_q   <= release_d;
            last_code_q <= last_code_d;
        end
    end

    assign bus.key_held    = held_q;
    assign bus.key_press   = press_q;
    assign bus.key_release = release_q;
    assign bus.any_held    = |held_q;
    assign bus.last_code   = last_code_q;

    if (REPEAT_EN) begin : g_repeat
        logic [IDX_W-1:0]    active_q, active_d;
        logic [NUM_KEYS-1:0] rpt_q, rpt_d;
        logic                load, stop, fire;

        // Lowest channel wins when duplicate codes press together; a press or
        // a release of the active channel suppresses a coinciding fire.
        always_comb begin
            active_d = active_q;
            load     = |press_d;
            for (int i = NUM_KEYS - 1; i >= 0; i--) begin
                if (press_d[i]) active_d = IDX_W'(i);
            end
            stop  = release_d[active_q];
            rpt_d = '0;
            if (fire && !load && !stop) rpt_d[active_q] = 1'b1;
        end

        always_ff @(posedge CLOCK_50) begin
            if (!resetn) begin
                active_q <= '0;
                rpt_q    <= '0;
            end else begin
                active_q <= active_d;
                rpt_q    <= rpt_d;
            end
        end

        ps2_repeat_timer #(
            .DELAY  (REPEAT_DELAY),
            .PERIOD (REPEAT_PERIOD)
        ) u_timer (
            .clk    (CLOCK_50),
            .resetn (resetn),
            .load   (load),
            .stop   (stop),
            .fire   (fire)
        );

        assign bus.key_repeat = rpt_q;
    end else begin : g_no_repeat
        assign bus.key_repeat = '0;
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: a table of byte sequences with
// hand-computed results, plus timed sequences for repeat, takeover and reset.
module tb_ps2_key_decoder;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_key_decoder_if #(.NUM_KEYS(5)) bus ();

    ps2_key_decoder #(
        .NUM_KEYS      (5),
        .KEY_CODES     ({8'h29, 8'h74, 8'h6B, 8'h72, 8'h75}),
        .KEY_EXT       (5'b01111),
        .REPEAT_EN     (1'b1),
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (8)
    ) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .bus      (bus)
    );

    typedef struct {
        int         t;
        logic [4:0] m;
    } rep_t;
    rep_t rq[$];

    always @(negedge clk) begin
        if (resetn && bus.key_repeat != 5'b0) rq.push_back('{cyc, bus.key_repeat});
    end

    typedef struct {
        int         len;
        logic [7:0] b0, b1, b2;
        logic [4:0] held, press, rel;
        logic [8:0] last;
    } vec_t;
    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge: drives one strobe, returns at the next negedge.
    task automatic send_byte(input logic [7:0] b);
        bus.received_data    = b;
        bus.received_data_en = 1'b1;
        @(negedge clk);
        bus.received_data_en = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        int guard = 0;
        while (cyc < t && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < t) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_cyc: reached %0d target %0d", cyc, t);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        bus.received_data_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    initial begin
        int c0, c1, c2;
        int t_off[5];

        vecs[0]  = '{2, 8'hE0, 8'h75, 8'h00, 5'b00001, 5'b00001, 5'b00000, 9'h175};
        vecs[1]  = '{3, 8'hE0, 8'hF0, 8'h75, 5'b00000, 5'b00000, 5'b00001, 9'h175};
        vecs[2]  = '{1, 8'h29, 8'h00, 8'h00, 5'b10000, 5'b10000, 5'b00000, 9'h029};
        vecs[3]  = '{1, 8'h29, 8'h00, 8'h00, 5'b10000, 5'b00000, 5'b00000, 9'h029};
        vecs[4]  = '{1, 8'h29, 8'h00, 8'h00, 5'b10000, 5'b00000, 5'b00000, 9'h029};
        vecs[5]  = '{1, 8'h29, 8'h00, 8'h00, 5'b10000, 5'b00000, 5'b00000, 9'h029};
        vecs[6]  = '{2, 8'hF0, 8'h29, 8'h00, 5'b00000, 5'b00000, 5'b10000, 9'h029};
        vecs[7]  = '{1, 8'h75, 8'h00, 8'h00, 5'b00000, 5'b00000, 5'b00000, 9'h075};
        vecs[8]  = '{2, 8'hF0, 8'h6B, 8'h00, 5'b00000, 5'b00000, 5'b00000, 9'h06B};
        vecs[9]  = '{2, 8'hE0, 8'h6B, 8'h00, 5'b00100, 5'b00100, 5'b00000, 9'h16B};
        vecs[10] = '{2, 8'hE0, 8'h74, 8'h00, 5'b01100, 5'b01000, 5'b00000, 9'h174};
        vecs[11] = '{2, 8'hF0, 8'h6B, 8'h00, 5'b01100, 5'b00000, 5'b00000, 9'h06B};
        vecs[12] = '{3, 8'hE0, 8'hF0, 8'h6B, 5'b01000, 5'b00000, 5'b00100, 9'h16B};
        vecs[13] = '{2, 8'hE1, 8'h14, 8'h00, 5'b01000, 5'b00000, 5'b00000, 9'h014};
        vecs[14] = '{3, 8'hE0, 8'hE0, 8'h72, 5'b01010, 5'b00010, 5'b00000, 9'h172};
        vecs[15] = '{2, 8'hF0, 8'hE0, 8'h00, 5'b01010, 5'b00000, 5'b00000, 9'h172};
        vecs[16] = '{3, 8'hE0, 8'hF0, 8'h72, 5'b01000, 5'b00000, 5'b00010, 9'h172};
        vecs[17] = '{3, 8'hE0, 8'hF0, 8'h74, 5'b00000, 5'b00000, 5'b01000, 9'h174};

        bus.received_data    = 8'h00;
        bus.received_data_en = 1'b0;

        // Reset state
        resetn = 1'b0;
        idle(3);
        check("rst_held",    32'(bus.key_held),    32'h0);
        check("rst_press",   32'(bus.key_press),   32'h0);
        check("rst_release", 32'(bus.key_release), 32'h0);
        check("rst_repeat",  32'(bus.key_repeat),  32'h0);
        check("rst_any",     32'(bus.any_held),    32'h0);
        check("rst_last",    32'(bus.last_code),   32'h0);
        resetn = 1'b1;
        idle(1);

        // Table-driven decode
        for (int v = 0; v < 18; v++) begin
            send_byte(vecs[v].b0);
            if (vecs[v].len > 1) send_byte(vecs[v].b1);
            if (vecs[v].len > 2) send_byte(vecs[v].b2);
            check($sformatf("v%0d_press", v),   32'(bus.key_press),   32'(vecs[v].press));
            check($sformatf("v%0d_release", v), 32'(bus.key_release), 32'(vecs[v].rel));
            check($sformatf("v%0d_held", v),    32'(bus.key_held),    32'(vecs[v].held));
            check($sformatf("v%0d_any", v),     32'(bus.any_held),    32'(vecs[v].held != 5'b0));
            check($sformatf("v%0d_last", v),    32'(bus.last_code),   32'(vecs[v].last));
            @(negedge clk);
            check($sformatf("v%0d_pulse_width", v),
                  32'({bus.key_press, bus.key_release}), 32'h0);
            idle(1);
        end

        // Auto-repeat timing, then a release landing on the expiry cycle
        do_reset();
        rq.delete();
        send_byte(8'hE0);
        send_byte(8'h74);
        c0 = cyc;
        check("rpt_press", 32'(bus.key_press), 32'b01000);
        wait_cyc(c0 + 55);
        send_byte(8'hE0);
        send_byte(8'hF0);
        wait_cyc(c0 + 59);
        send_byte(8'h74);
        check("rpt_release", 32'(bus.key_release), 32'b01000);
        check("rpt_release_no_pulse", 32'(bus.key_repeat), 32'h0);
        idle(20);
        check("rpt_count", 32'(rq.size()), 32'd5);
        t_off = '{20, 28, 36, 44, 52};
        for (int k = 0; k < 5 && k < rq.size(); k++) begin
            check($sformatf("rpt%0d_time", k), 32'(rq[k].t - c0), 32'(t_off[k]));
            check($sformatf("rpt%0d_chan", k), 32'(rq[k].m), 32'b01000);
        end

        // Takeover on the old channel's expiry cycle, then release of the old channel
        do_reset();
        rq.delete();
        send_byte(8'hE0);
        send_byte(8'h75);
        c1 = cyc;
        check("tko_up_press", 32'(bus.key_press), 32'b00001);
        wait_cyc(c1 + 17);
        send_byte(8'hE0);
        wait_cyc(c1 + 19);
        send_byte(8'h72);
        c2 = cyc;
        check("tko_down_press", 32'(bus.key_press), 32'b00010);
        check("tko_no_old_repeat", 32'(bus.key_repeat), 32'h0);
        wait_cyc(c2 + 22);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        check("tko_up_release", 32'(bus.key_release), 32'b00001);
        check("tko_held", 32'(bus.key_held), 32'b00010);
        wait_cyc(c2 + 40);
        check("tko_count", 32'(rq.size()), 32'd3);
        for (int k = 0; k < 3 && k < rq.size(); k++) begin
            check($sformatf("tko%0d_time", k), 32'(rq[k].t - c2), 32'(20 + 8 * k));
            check($sformatf("tko%0d_chan", k), 32'(rq[k].m), 32'b00010);
        end

        // Reset mid-sequence; a byte during reset is dropped
        do_reset();
        send_byte(8'h29);
        check("mid_held_before", 32'(bus.key_held), 32'b10000);
        send_byte(8'hE0);
        send_byte(8'hF0);
        resetn = 1'b0;
        bus.received_data    = 8'h29;
        bus.received_data_en = 1'b1;
        @(negedge clk);
        bus.received_data_en = 1'b0;
        check("mid_rst_held",   32'(bus.key_held),    32'h0);
        check("mid_rst_any",    32'(bus.any_held),    32'h0);
        check("mid_rst_last",   32'(bus.last_code),   32'h0);
        check("mid_rst_pulses", 32'({bus.key_press, bus.key_release, bus.key_repeat}), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        send_byte(8'h75);
        check("mid_post_press", 32'(bus.key_press), 32'h0);
        check("mid_post_held",  32'(bus.key_held),  32'h0);
        check("mid_post_last",  32'(bus.last_code), 32'h075);
        send_byte(8'hE0);
        send_byte(8'h75);
        check("mid_post_ext_press", 32'(bus.key_press), 32'b00001);

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
